vram_arbiter: RTL and testbench

- Shares one single-port synchronous video RAM between two users.
  - The VGA pixel fetch path is real-time and always wins.
  - The drawing-engine write port is buffered and opportunistic.
- Sits between vga_controller (row/column/active timing) and the framebuffer RAM.
- Delivers the fetched pixel colour with a fixed, documented latency.
- Queues pixel writes and drains them into RAM only in cycles the display does not need.

---
 rtl/vga_pkg.sv | 16 +
 rtl/vram_wr_fifo.sv | 51 +++++
 rtl/vram_arbiter.sv | 109 ++++++++++
 tb/tb_vram_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared video timing constants and VRAM port-state encoding
package vga_pkg;

  localparam int H_TOTAL  = 800;
  localparam int V_TOTAL  = 521;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int FB_WORDS = 307200;

  typedef enum logic [1:0] {
    PORT_IDLE  = 2'd0,
    PORT_FETCH = 2'd1,
    PORT_WRITE = 2'd2
  } port_state_e;

endpackage

// File: rtl/vram_wr_fifo.sv
// rtl/vram_wr_fifo.sv - show-ahead sync FIFO buffering drawing-engine writes
module vram_wr_fifo #(
  parameter int WIDTH = 22,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - single-port VRAM arbiter: display fetch always wins,
// queued drawing writes drain in cycles the display does not need.
module vram_arbiter #(
  parameter int ADDR_W        = 19,
  parameter int DATA_W        = 3,
  parameter int FIFO_DEPTH    = 4,
  parameter int HBLANK_WRITES = 1,
  parameter int FB_WORDS      = vga_pkg::FB_WORDS
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              disp_active,
  input  logic              disp_vblank,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] pixel_rgb,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);
  import vga_pkg::*;

  port_state_e                  state_q, state_d;
  logic [ADDR_W-1:0]            mem_addr_q, mem_addr_d;
  logic                         mem_we_q, mem_we_d;
  logic [DATA_W-1:0]            mem_wdata_q, mem_wdata_d;
  logic                         rvalid_q;
  logic [DATA_W-1:0]            pixel_q;

  logic [ADDR_W+DATA_W-1:0]     fifo_head;
  logic [ADDR_W-1:0]            head_addr;
  logic [DATA_W-1:0]            head_data;
  logic                         fifo_full, fifo_empty, fifo_pop;
  logic [$clog2(FIFO_DEPTH):0]  fifo_count;
  logic                         drain_ok, head_in_range;

  vram_wr_fifo #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .push_i      (wr_valid && wr_ready),
    .push_data_i ({wr_addr, wr_data}),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign head_addr     = fifo_head[ADDR_W+DATA_W-1:DATA_W];
  assign head_data     = fifo_head[DATA_W-1:0];
  assign head_in_range = (head_addr < ADDR_W'(FB_WORDS));
  assign drain_ok      = (HBLANK_WRITES != 0) || disp_vblank;

  // Out-of-range entries are popped like any other but never drive the RAM.
  always_comb begin
    state_d     = PORT_IDLE;
    fifo_pop    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    if (disp_active) begin
      state_d    = PORT_FETCH;
      mem_addr_d = disp_addr;
    end else if (!fifo_empty && drain_ok) begin
      state_d  = PORT_WRITE;
      fifo_pop = 1'b1;
      if (head_in_range) begin
        mem_addr_d  = head_addr;
        mem_wdata_d = head_data;
        mem_we_d    = 1'b1;
      end
    end
  end

  // Fetch valid travels with the data: state_q -> rvalid_q -> pixel_q.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= PORT_IDLE;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      rvalid_q    <= 1'b0;
      pixel_q     <= '0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      rvalid_q    <= (state_q == PORT_FETCH);
      pixel_q     <= rvalid_q ? mem_rdata : '0;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign pixel_rgb = pixel_q;
  assign wr_ready  = !fifo_full && !reset;
  assign busy      = (fifo_count != '0) || mem_we_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - checks two arbiters (HBLANK_WRITES=0 and 1) against a queue-based model
module tb_vram_arbiter;
  localparam int AW = 19, DW = 3, DEPTH = 4, FBW = 307200;

  logic clock = 1'b0, reset = 1'b1;
  logic disp_active = 1'b0, disp_vblank = 1'b0, wr_valid = 1'b0;
  logic [AW-1:0] disp_addr = '0, wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [1:0][DW-1:0] pixel_rgb, mem_wdata, mem_rdata;
  logic [1:0][AW-1:0] mem_addr;
  logic [1:0] wr_ready, mem_we, busy;

  int n_checks = 0, n_pass = 0;

  always #5 clock = ~clock;

  vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .HBLANK_WRITES(0), .FB_WORDS(FBW)) dut0 (
    .clock(clock), .reset(reset), .disp_active(disp_active), .disp_vblank(disp_vblank),
    .disp_addr(disp_addr), .pixel_rgb(pixel_rgb[0]), .wr_valid(wr_valid), .wr_ready(wr_ready[0]),
    .wr_addr(wr_addr), .wr_data(wr_data), .mem_addr(mem_addr[0]), .mem_we(mem_we[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]), .busy(busy[0]));

  vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .HBLANK_WRITES(1), .FB_WORDS(FBW)) dut1 (
    .clock(clock), .reset(reset), .disp_active(disp_active), .disp_vblank(disp_vblank),
    .disp_addr(disp_addr), .pixel_rgb(pixel_rgb[1]), .wr_valid(wr_valid), .wr_ready(wr_ready[1]),
    .wr_addr(wr_addr), .wr_data(wr_data), .mem_addr(mem_addr[1]), .mem_we(mem_we[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]), .busy(busy[1]));

  // Framebuffer RAMs attached to each DUT: one-cycle read, read-before-write.
  logic [DW-1:0] ram [2][FBW];
  initial begin
    for (int g = 0; g < 2; g++) for (int a = 0; a < FBW; a++) ram[g][a] = '0;
    forever begin
      @(posedge clock);
      for (int g = 0; g < 2; g++) begin
        if (int'(mem_addr[g]) < FBW) begin
          mem_rdata[g] <= ram[g][mem_addr[g]];
          if (mem_we[g]) ram[g][mem_addr[g]] = mem_wdata[g];
        end
      end
    end
  end

  // Reference model: write queue, expected framebuffer, pixel history.
  int            mq [2][$];
  int            ph [2][$];
  logic [DW-1:0] fb [2][FBW];
  bit            m_we [2], m_fetch [2], m_rst [2];
  int            m_addr [2], m_wd [2];

  task automatic chk(input string nm, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
  endtask

  task automatic model_step(input int i);
    bit accept, nonempty;
    int pix, e, a;
    if (reset) begin
      mq[i].delete(); ph[i].delete();
      m_we[i] = 0; m_fetch[i] = 0; m_rst[i] = 1; m_addr[i] = 0; m_wd[i] = 0;
      return;
    end
    m_rst[i]   = 0;
    accept     = wr_valid && (mq[i].size() < DEPTH);
    nonempty   = (mq[i].size() > 0);
    pix        = 0;
    m_we[i]    = 0;
    m_fetch[i] = 0;
    if (disp_active) begin
      m_fetch[i] = 1;
      m_addr[i]  = int'(disp_addr);
      pix        = int'(fb[i][disp_addr]);
    end else if (nonempty && (i == 1 || disp_vblank)) begin
      e = mq[i].pop_front();
      a = e / 8;
      if (a < FBW) begin
        m_we[i] = 1; m_addr[i] = a; m_wd[i] = e % 8;
        fb[i][a] = DW'(e % 8);
      end
    end
    if (accept) mq[i].push_back(int'(wr_addr) * 8 + int'(wr_data));
    ph[i].push_back(pix);
    if (ph[i].size() > 3) void'(ph[i].pop_front());
  endtask

  task automatic compare(input int i);
    string p;
    p = $sformatf("dut%0d ", i);
    chk({p, "mem_we"}, int'(mem_we[i]), int'(m_we[i]));
    chk({p, "busy"}, int'(busy[i]), int'(mq[i].size() != 0 || m_we[i]));
    chk({p, "wr_ready"}, int'(wr_ready[i]), int'(!reset && mq[i].size() < DEPTH));
    chk({p, "pixel_rgb"}, int'(pixel_rgb[i]), (ph[i].size() == 3) ? ph[i][0] : 0);
    if (m_we[i] || m_fetch[i] || m_rst[i]) chk({p, "mem_addr"}, int'(mem_addr[i]), m_addr[i]);
    if (m_we[i] || m_rst[i]) chk({p, "mem_wdata"}, int'(mem_wdata[i]), m_wd[i]);
  endtask

  initial begin
    for (int g = 0; g < 2; g++) for (int a = 0; a < FBW; a++) fb[g][a] = '0;
    forever begin
      @(posedge clock);
      model_step(0);
      model_step(1);
      #1;
      compare(0);
      compare(1);
    end
  end

  task automatic cyc(input bit act, input bit vb, input int da, input bit wv, input int wa, input int wd);
    @(negedge clock);
    disp_active = act; disp_vblank = vb; disp_addr = AW'(da);
    wr_valid = wv; wr_addr = AW'(wa); wr_data = DW'(wd);
    @(posedge clock);
    #2;
  endtask

  initial begin
    int wa;
    bit act, vb;
    // Reset state
    repeat (3) cyc(0, 0, 0, 0, 0, 0);
    chk("rst pixel", int'(pixel_rgb[1]), 0);
    chk("rst wr_ready", int'(wr_ready[1]), 0);
    chk("rst busy", int'(busy[1]), 0);
    chk("rst mem_we", int'(mem_we[1]), 0);
    reset = 1'b0;
    cyc(0, 0, 0, 0, 0, 0);
    chk("wr_ready after reset", int'(wr_ready[1]), 1);

    // Preload addr 5 = 3'b101, then read it back with 3-cycle latency
    cyc(0, 1, 0, 1, 5, 5);
    repeat (3) cyc(0, 1, 0, 0, 0, 0);
    cyc(1, 0, 5, 0, 0, 0);
    chk("lat mem_addr t+1", int'(mem_addr[1]), 5);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("lat pixel t+3", int'(pixel_rgb[1]), 5);
    cyc(0, 0, 0, 0, 0, 0);
    chk("lat pixel t+4", int'(pixel_rgb[1]), 0);

    // Priority and full: 5 pushes under active video
    for (int k = 0; k < 5; k++) begin
      cyc(1, 0, int'($urandom_range(0, 31)), 1, 100 + k, k + 1);
      chk("full mem_we active", int'(mem_we[1]), 0);
      if (k == 3) chk("full wr_ready", int'(wr_ready[1]), 0);
    end
    cyc(1, 0, 7, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      cyc(0, 0, 0, 0, 0, 0);
      chk("drain mem_we", int'(mem_we[1]), 1);
      chk("drain mem_addr", int'(mem_addr[1]), 100 + k);
      chk("drain mem_wdata", int'(mem_wdata[1]), k + 1);
      chk("hblank0 mem_we", int'(mem_we[0]), 0);
    end
    cyc(0, 0, 0, 0, 0, 0);
    chk("drained busy", int'(busy[1]), 0);
    for (int k = 0; k < 4; k++) begin
      cyc(0, 1, 0, 0, 0, 0);
      chk("vblank mem_we", int'(mem_we[0]), 1);
      chk("vblank mem_addr", int'(mem_addr[0]), 100 + k);
    end
    cyc(0, 1, 0, 0, 0, 0);

    // Out-of-range write is consumed silently
    cyc(0, 1, 0, 1, FBW, 3);
    cyc(0, 1, 0, 1, FBW - 1, 2);
    chk("oor no write", int'(mem_we[1]), 0);
    cyc(0, 1, 0, 0, 0, 0);
    chk("oor edge mem_we", int'(mem_we[1]), 1);
    chk("oor edge mem_addr", int'(mem_addr[1]), FBW - 1);
    chk("oor edge mem_wdata", int'(mem_wdata[1]), 2);
    repeat (2) cyc(0, 1, 0, 0, 0, 0);

    // Simultaneous push/pop keeps occupancy at 2
    cyc(1, 0, 3, 1, 20, 1);
    cyc(1, 0, 4, 1, 21, 2);
    for (int k = 0; k < 6; k++) begin
      cyc(0, 1, 0, 1, 22 + k, (3 + k) % 8);
      chk("pp count", int'(dut1.u_fifo.count_o), 2);
      chk("pp wr_ready", int'(wr_ready[1]), 1);
      chk("pp mem_we", int'(mem_we[1]), 1);
      chk("pp mem_addr", int'(mem_addr[1]), 20 + k);
    end
    repeat (4) cyc(0, 1, 0, 0, 0, 0);

    // Reset mid-burst discards queued writes
    for (int k = 0; k < 3; k++) cyc(1, 0, k, 1, 40 + k, k);
    reset = 1'b1;
    repeat (2) begin
      cyc(0, 1, 0, 0, 0, 0);
      chk("mid rst mem_we", int'(mem_we[1]), 0);
      chk("mid rst pixel", int'(pixel_rgb[1]), 0);
      chk("mid rst busy", int'(busy[1]), 0);
    end
    reset = 1'b0;
    cyc(0, 1, 0, 0, 0, 0);
    chk("post rst wr_ready", int'(wr_ready[1]), 1);
    repeat (4) begin
      cyc(0, 1, 0, 0, 0, 0);
      chk("post rst mem_we", int'(mem_we[1]), 0);
    end

    // Randomised line/frame-shaped traffic with occasional resets
    for (int c = 0; c < 4000; c++) begin
      vb  = ((c / 300) % 3) == 2;
      act = !vb && ((c % 40) < 26) && ($urandom_range(0, 15) != 0);
      case ($urandom_range(0, 9))
        0:       wa = FBW;
        1:       wa = FBW - 1;
        2:       wa = (1 << AW) - 1;
        default: wa = int'($urandom_range(0, 31));
      endcase
      reset = ($urandom_range(0, 599) == 0);
      cyc(act, vb, int'($urandom_range(0, 31)), $urandom_range(0, 2) != 0, wa,
          int'($urandom_range(0, 7)));
    end
    reset = 1'b0;
    repeat (3) cyc(0, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
